// File: rtl/dot_seq_pkg.sv
// Shared types and widths for the word-serial bitwise dot-product controller.
package dot_seq_pkg;

  localparam int WORD_W     = 32;
  localparam int WORD_RES_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dot_word.sv
// Combinational per-word bitwise dot product: popcount(a & b).
module dot_word
  import dot_seq_pkg::*;
(
  input  logic [WORD_W-1:0]     a,
  input  logic [WORD_W-1:0]     b,
  output logic [WORD_RES_W-1:0] res
);

  logic [WORD_W-1:0] masked;

  assign masked = a & b;

  always_comb begin
    res = '0;
    for (int i = 0; i < WORD_W; i++) begin
      res = res + WORD_RES_W'(masked[i]);
    end
  end

endmodule

// File: rtl/dot_product_seq.sv
// Word-serial dot-product controller: accepts LEN word pairs, accumulates popcount(a&b), returns the sum.
// Optional abort input is added when DOTSEQ_ABORT_EN is defined.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// in_ready depends only on state, and out_valid/result stay stable until out_ready is seen.
module dot_product_seq
  import dot_seq_pkg::*;
#(
  parameter int MAX_WORDS = 16,
  parameter int LEN_W     = $clog2(MAX_WORDS + 1),
  parameter int ACC_W     = 6 + $clog2(MAX_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] vec_a,
  input  logic [WORD_W-1:0] vec_b,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result
`ifdef DOTSEQ_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_t                state_q;
  state_t                state_d;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      cnt_q;
  logic [ACC_W-1:0]      acc_q;
  logic [LEN_W-1:0]      len_clamped;
  logic [WORD_RES_W-1:0] word_res;
  logic                  xfer;
  logic                  last_pair;
  logic                  abort_i;
  logic                  kill;

`ifdef DOTSEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Abort only matters once a job is in flight.
  assign kill        = abort_i && (state_q != IDLE);
  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign xfer        = in_valid && in_ready;
  assign last_pair   = (cnt_q == (len_q - LEN_W'(1)));

  dot_word u_dot_word (
    .a   (vec_a),
    .b   (vec_b),
    .res (word_res)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (xfer && last_pair) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
    end
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == RUN);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    result    = acc_q;
  end

  // Job length, pair counter and accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
    end else if (kill) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        len_q <= len_clamped;
        cnt_q <= '0;
        acc_q <= '0;
      end else if (xfer) begin
        cnt_q <= cnt_q + LEN_W'(1);
        acc_q <= acc_q + ACC_W'(word_res);
      end
    end
  end

endmodule

// File: tb/tb_dot_product_seq.sv
// Directed self-checking bench for dot_product_seq; covers the abort path when DOTSEQ_ABORT_EN is defined.
module tb_dot_product_seq;

  localparam int LEN_W = 5;
  localparam int ACC_W = 10;

  logic             clk;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      vec_a;
  logic [31:0]      vec_b;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
`ifdef DOTSEQ_ABORT_EN
  logic             abort;
`endif

  dot_product_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec_a     (vec_a),
    .vec_b     (vec_b),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef DOTSEQ_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          xfer_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] a_mem[0:31];
  logic [31:0] b_mem[0:31];

  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic start_job(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    tick();
    start = 1'b0;
    len   = LEN_W'($urandom_range(0, 31));
  endtask

  task automatic feed(input int lo, input int hi, input bit gaps);
    for (int i = lo; i < hi; i++) begin
      if (gaps && (i % 2 == 1)) begin
        in_valid = 1'b0;
        vec_a    = $urandom;
        vec_b    = $urandom;
        tick();
      end
      in_valid = 1'b1;
      vec_a    = a_mem[i];
      vec_b    = b_mem[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    logic [31:0] e;
    int w;
    w = 0;
    out_ready = 1'b0;
    while (!out_valid && w < 100) begin
      tick();
      w++;
    end
    check("out_valid_wait", 32'(out_valid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hffff_ffff;
    check("result", 32'(result), e);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), e);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_hs", 32'(busy), 32'd0);
  endtask

  task automatic load_basic();
    a_mem[0] = 32'd3;  b_mem[0] = 32'd6;
    a_mem[1] = 32'd13; b_mem[1] = 32'd15;
    a_mem[2] = 32'd33; b_mem[2] = 32'd31;
    a_mem[3] = 32'd14; b_mem[3] = 32'd15;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    vec_a     = '0;
    vec_b     = '0;
    out_ready = 1'b0;
`ifdef DOTSEQ_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    reset = 1'b0;
    tick();

    // Basic job back-to-back: 1+3+1+3 = 8
    load_basic();
    exp_q.push_back(32'd8);
    start_job(4);
    check("run_in_ready", 32'(in_ready), 32'd1);
    x0 = xfer_cnt;
    feed(0, 3, 1'b0);
    check("not_done_early", 32'(out_valid), 32'd0);
    feed(3, 4, 1'b0);
    check("latency", 32'(out_valid), 32'd1);
    check("consumed_4", 32'(xfer_cnt - x0), 32'd4);
    collect(0);

    // Bubbles and backpressure
    exp_q.push_back(32'd8);
    start_job(4);
    x0 = xfer_cnt;
    feed(0, 4, 1'b1);
    check("consumed_gaps", 32'(xfer_cnt - x0), 32'd4);
    collect(3);

    // len=0: immediate result 0, pairs on the bus are not consumed
    exp_q.push_back(32'd0);
    x0 = xfer_cnt;
    start_job(0);
    check("len0_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    vec_a    = 32'hffff_ffff;
    vec_b    = 32'hffff_ffff;
    check("len0_in_ready", 32'(in_ready), 32'd0);
    collect(1);
    in_valid = 1'b0;
    check("len0_consumed", 32'(xfer_cnt - x0), 32'd0);

    // len=16 all ones: 16*32 = 512
    for (int i = 0; i < 32; i++) begin
      a_mem[i] = 32'hffff_ffff;
      b_mem[i] = 32'hffff_ffff;
    end
    exp_q.push_back(32'd512);
    start_job(16);
    x0 = xfer_cnt;
    feed(0, 16, 1'b0);
    check("len16_consumed", 32'(xfer_cnt - x0), 32'd16);
    collect(0);

    // len=20 clamps to 16 pairs
    exp_q.push_back(32'd512);
    start_job(20);
    x0 = xfer_cnt;
    feed(0, 20, 1'b0);
    check("len20_consumed", 32'(xfer_cnt - x0), 32'd16);
    collect(0);

    // Start pulses during RUN and DONE are ignored: (13,15)+(3,6) = 3+1 = 4
    a_mem[0] = 32'd13; b_mem[0] = 32'd15;
    a_mem[1] = 32'd3;  b_mem[1] = 32'd6;
    exp_q.push_back(32'd4);
    start_job(2);
    x0    = xfer_cnt;
    start = 1'b1;
    len   = LEN_W'(5);
    feed(0, 2, 1'b0);
    tick();
    start = 1'b0;
    check("ign_consumed", 32'(xfer_cnt - x0), 32'd2);
    check("ign_still_done", 32'(out_valid), 32'd1);
    collect(0);

    // Reset held 2 cycles mid-RUN
    load_basic();
    start_job(4);
    feed(0, 2, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_result", 32'(result), 32'd0);

`ifdef DOTSEQ_ABORT_EN
    // Abort after 2 of 4 pairs, then a fresh 1-pair job: (13,15) = 3
    load_basic();
    start_job(4);
    feed(0, 2, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    repeat (3) tick();
    check("abort_no_result", 32'(out_valid), 32'd0);
    a_mem[0] = 32'd13; b_mem[0] = 32'd15;
    exp_q.push_back(32'd3);
    start_job(1);
    feed(0, 1, 1'b0);
    collect(0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
